// File: rtl/pair_distance_generator_if.sv
// Point-load and distance-stream bundle for pair_distance_generator.
//   pt_valid/pt_ready/pt_x/pt_y/pt_z/pt_last : point list input channel
//   out_valid/out_data/out_id1/out_id2/out_last : pair distance stream (no backpressure)
// modport slave  : the generator side
// modport master : the producer of points / consumer of distances
interface pair_distance_generator_if #(
   parameter int COORD_WIDTH = 20,
   parameter int DIST_WIDTH  = 64,
   parameter int INDEX_WIDTH = 32
);
   logic                   pt_valid;
   logic                   pt_ready;
   logic [COORD_WIDTH-1:0] pt_x;
   logic [COORD_WIDTH-1:0] pt_y;
   logic [COORD_WIDTH-1:0] pt_z;
   logic                   pt_last;

   logic                   out_valid;
   logic [DIST_WIDTH-1:0]  out_data;
   logic [INDEX_WIDTH-1:0] out_id1;
   logic [INDEX_WIDTH-1:0] out_id2;
   logic                   out_last;

   modport slave (
      input  pt_valid, pt_x, pt_y, pt_z, pt_last,
      output pt_ready,
      output out_valid, out_data, out_id1, out_id2, out_last
   );

   modport master (
      output pt_valid, pt_x, pt_y, pt_z, pt_last,
      input  pt_ready,
      input  out_valid, out_data, out_id1, out_id2, out_last
   );
endinterface

// File: rtl/pair_distance_generator.sv
// Loads a list of 3D points, then streams the squared Euclidean distance of
// every unordered pair (i<j), one beat per cycle, to the systolic sorter.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : point input channel and distance output stream
//   point_count   : number of points stored
//   overflow      : sticky, a point arrived while the memory was full
//   done          : generation finished, held until rst
module pair_distance_generator #(
   parameter int MAX_POINTS  = 1024,
   parameter int COORD_WIDTH = 20,
   parameter int DIST_WIDTH  = 64,
   parameter int INDEX_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   pair_distance_generator_if.slave bus,
   output logic [INDEX_WIDTH-1:0] point_count,
   output logic                   overflow,
   output logic                   done
);
   localparam int ADDR_WIDTH = (MAX_POINTS > 1) ? $clog2(MAX_POINTS) : 1;
   localparam int DIFF_WIDTH = COORD_WIDTH + 1;
   localparam int SQ_WIDTH   = 2 * DIFF_WIDTH;
   localparam int SUM_WIDTH  = 2 * COORD_WIDTH + 4;
   localparam int PT_WIDTH   = 3 * COORD_WIDTH;

   typedef enum logic [1:0] {ST_LOAD, ST_GEN, ST_DRAIN, ST_DONE} state_t;

   state_t state, next_state;

   logic [PT_WIDTH-1:0]    point_mem [MAX_POINTS];
   logic [INDEX_WIDTH-1:0] idx_i, idx_j;
   logic [INDEX_WIDTH-1:0] count_after;
   logic                   accept, has_room, j_at_end, last_pair, issue;

   logic                   s1_valid, s1_last;
   logic [INDEX_WIDTH-1:0] s1_i, s1_j;
   logic [PT_WIDTH-1:0]    s1_pt_i, s1_pt_j;

   logic                   s2_valid, s2_last;
   logic [INDEX_WIDTH-1:0] s2_i, s2_j;
   logic signed [DIFF_WIDTH-1:0] s2_dx, s2_dy, s2_dz;

   logic signed [SQ_WIDTH-1:0] sq_x, sq_y, sq_z;
   logic [SUM_WIDTH-1:0]       dist_sum;

   // The last pair is the one where j hits N-1 while i is right behind it.
   always_comb begin
      accept      = bus.pt_valid && (state == ST_LOAD);
      has_room    = point_count < INDEX_WIDTH'(MAX_POINTS);
      count_after = has_room ? point_count + INDEX_WIDTH'(1) : point_count;
      issue       = (state == ST_GEN);
      j_at_end    = (idx_j == point_count - INDEX_WIDTH'(1));
      last_pair   = j_at_end && (idx_i + INDEX_WIDTH'(1) == idx_j);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_LOAD;
      else     state <= next_state;
   end

   always_comb begin
      next_state   = state;
      bus.pt_ready = (state == ST_LOAD);
      done         = (state == ST_DONE);
      case (state)
         ST_LOAD:
            if (accept && bus.pt_last)
               next_state = (count_after >= INDEX_WIDTH'(2)) ? ST_GEN : ST_DONE;
         ST_GEN:
            if (last_pair) next_state = ST_DRAIN;
         ST_DRAIN:
            if (!s1_valid && !s2_valid && !bus.out_valid) next_state = ST_DONE;
         default: next_state = state;
      endcase
   end

   // Datapath with no reset: point storage, synchronous dual read, differences.
   // Differences are taken on zero-extended coordinates so they never wrap.
   always_ff @(posedge clk) begin
      if (accept && has_room)
         point_mem[point_count[ADDR_WIDTH-1:0]] <= {bus.pt_x, bus.pt_y, bus.pt_z};
      s1_pt_i <= point_mem[idx_i[ADDR_WIDTH-1:0]];
      s1_pt_j <= point_mem[idx_j[ADDR_WIDTH-1:0]];
      s2_dx <= $signed({1'b0, s1_pt_j[PT_WIDTH-1 -: COORD_WIDTH]})
             - $signed({1'b0, s1_pt_i[PT_WIDTH-1 -: COORD_WIDTH]});
      s2_dy <= $signed({1'b0, s1_pt_j[2*COORD_WIDTH-1 -: COORD_WIDTH]})
             - $signed({1'b0, s1_pt_i[2*COORD_WIDTH-1 -: COORD_WIDTH]});
      s2_dz <= $signed({1'b0, s1_pt_j[COORD_WIDTH-1:0]})
             - $signed({1'b0, s1_pt_i[COORD_WIDTH-1:0]});
   end

   // Squares are non-negative, so zero-extending them into the sum is exact.
   always_comb begin
      sq_x     = SQ_WIDTH'(s2_dx) * SQ_WIDTH'(s2_dx);
      sq_y     = SQ_WIDTH'(s2_dy) * SQ_WIDTH'(s2_dy);
      sq_z     = SQ_WIDTH'(s2_dz) * SQ_WIDTH'(s2_dz);
      dist_sum = SUM_WIDTH'($unsigned(sq_x)) + SUM_WIDTH'($unsigned(sq_y))
               + SUM_WIDTH'($unsigned(sq_z));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         point_count   <= '0;
         overflow      <= 1'b0;
         idx_i         <= '0;
         idx_j         <= INDEX_WIDTH'(1);
         s1_valid      <= 1'b0;
         s1_last       <= 1'b0;
         s1_i          <= '0;
         s1_j          <= '0;
         s2_valid      <= 1'b0;
         s2_last       <= 1'b0;
         s2_i          <= '0;
         s2_j          <= '0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_id1   <= '0;
         bus.out_id2   <= '0;
         bus.out_last  <= 1'b0;
      end else begin
         if (accept) begin
            if (has_room) point_count <= point_count + INDEX_WIDTH'(1);
            else          overflow    <= 1'b1;
         end
         // Row-major walk: after (i, N-1) comes (i+1, i+2).
         if (issue) begin
            if (j_at_end) begin
               idx_i <= idx_i + INDEX_WIDTH'(1);
               idx_j <= idx_i + INDEX_WIDTH'(2);
            end else begin
               idx_j <= idx_j + INDEX_WIDTH'(1);
            end
         end
         s1_valid      <= issue;
         s1_last       <= issue && last_pair;
         s1_i          <= idx_i;
         s1_j          <= idx_j;
         s2_valid      <= s1_valid;
         s2_last       <= s1_last;
         s2_i          <= s1_i;
         s2_j          <= s1_j;
         bus.out_valid <= s2_valid;
         if (s2_valid) begin
            bus.out_data <= DIST_WIDTH'(dist_sum);
            bus.out_id1  <= s2_i;
            bus.out_id2  <= s2_j;
            bus.out_last <= s2_last;
         end
      end
   end
endmodule

// File: tb/tb_pair_distance_generator.sv
// Self-checking bench for pair_distance_generator. Three instances with
// MAX_POINTS of 1024, 1 and 4 share one stimulus driver; sel picks which one
// sees pt_valid and which one is observed.
module tb_pair_distance_generator;
   localparam int CW = 20;
   localparam int DW = 64;
   localparam int IW = 32;

   typedef struct packed {
      logic [IW-1:0] id1;
      logic [IW-1:0] id2;
      logic [DW-1:0] d;
      logic          last;
   } beat_t;

   typedef struct {
      logic [CW-1:0] ax, ay, az;
      logic [CW-1:0] bx, by, bz;
      longint        d;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int            sel;
   logic          tb_valid, tb_last;
   logic [CW-1:0] tb_x, tb_y, tb_z;

   int     checks = 0;
   int     errors = 0;
   beat_t  exp_q[$];
   longint mdl_x[$], mdl_y[$], mdl_z[$];

   pair_distance_generator_if #(.COORD_WIDTH(CW), .DIST_WIDTH(DW), .INDEX_WIDTH(IW)) bus_big ();
   pair_distance_generator_if #(.COORD_WIDTH(CW), .DIST_WIDTH(DW), .INDEX_WIDTH(IW)) bus_one ();
   pair_distance_generator_if #(.COORD_WIDTH(CW), .DIST_WIDTH(DW), .INDEX_WIDTH(IW)) bus_four ();

   assign bus_big.pt_valid  = tb_valid && (sel == 0);
   assign bus_one.pt_valid  = tb_valid && (sel == 1);
   assign bus_four.pt_valid = tb_valid && (sel == 2);
   assign bus_big.pt_x  = tb_x;  assign bus_big.pt_y  = tb_y;  assign bus_big.pt_z  = tb_z;
   assign bus_one.pt_x  = tb_x;  assign bus_one.pt_y  = tb_y;  assign bus_one.pt_z  = tb_z;
   assign bus_four.pt_x = tb_x;  assign bus_four.pt_y = tb_y;  assign bus_four.pt_z = tb_z;
   assign bus_big.pt_last  = tb_last;
   assign bus_one.pt_last  = tb_last;
   assign bus_four.pt_last = tb_last;

   logic [IW-1:0] cnt_big, cnt_one, cnt_four;
   logic          ovf_big, ovf_one, ovf_four;
   logic          done_big, done_one, done_four;

   pair_distance_generator #(.MAX_POINTS(1024), .COORD_WIDTH(CW), .DIST_WIDTH(DW), .INDEX_WIDTH(IW)) dut_big (
      .clk(clk), .rst(rst), .bus(bus_big), .point_count(cnt_big), .overflow(ovf_big), .done(done_big));
   pair_distance_generator #(.MAX_POINTS(1), .COORD_WIDTH(CW), .DIST_WIDTH(DW), .INDEX_WIDTH(IW)) dut_one (
      .clk(clk), .rst(rst), .bus(bus_one), .point_count(cnt_one), .overflow(ovf_one), .done(done_one));
   pair_distance_generator #(.MAX_POINTS(4), .COORD_WIDTH(CW), .DIST_WIDTH(DW), .INDEX_WIDTH(IW)) dut_four (
      .clk(clk), .rst(rst), .bus(bus_four), .point_count(cnt_four), .overflow(ovf_four), .done(done_four));

   logic          o_valid, o_last, o_ready, o_ovf, o_done;
   logic [DW-1:0] o_data;
   logic [IW-1:0] o_id1, o_id2, o_count;

   // Observe whichever instance is currently selected.
   always_comb begin
      o_valid = bus_big.out_valid; o_data = bus_big.out_data; o_id1 = bus_big.out_id1;
      o_id2 = bus_big.out_id2; o_last = bus_big.out_last; o_ready = bus_big.pt_ready;
      o_count = cnt_big; o_ovf = ovf_big; o_done = done_big;
      if (sel == 1) begin
         o_valid = bus_one.out_valid; o_data = bus_one.out_data; o_id1 = bus_one.out_id1;
         o_id2 = bus_one.out_id2; o_last = bus_one.out_last; o_ready = bus_one.pt_ready;
         o_count = cnt_one; o_ovf = ovf_one; o_done = done_one;
      end else if (sel == 2) begin
         o_valid = bus_four.out_valid; o_data = bus_four.out_data; o_id1 = bus_four.out_id1;
         o_id2 = bus_four.out_id2; o_last = bus_four.out_last; o_ready = bus_four.pt_ready;
         o_count = cnt_four; o_ovf = ovf_four; o_done = done_four;
      end
   end

   task automatic checkValue(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   task automatic resetAll();
      rst      = 1'b1;
      tb_valid = 1'b0;
      tb_last  = 1'b0;
      tb_x = '0; tb_y = '0; tb_z = '0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
      mdl_x.delete(); mdl_y.delete(); mdl_z.delete();
   endtask

   // One point per cycle; the model keeps only what the selected instance can hold.
   task automatic applyStimulus(input longint x, input longint y, input longint z, input bit last);
      int cap;
      cap = (sel == 1) ? 1 : (sel == 2) ? 4 : 1024;
      @(negedge clk);
      tb_x = CW'(x); tb_y = CW'(y); tb_z = CW'(z);
      tb_valid = 1'b1;
      tb_last  = last;
      @(posedge clk);
      #1 tb_valid = 1'b0;
      tb_last = 1'b0;
      if (mdl_x.size() < cap) begin
         mdl_x.push_back(x); mdl_y.push_back(y); mdl_z.push_back(z);
      end
   endtask

   task automatic pushBeat(input longint id1, input longint id2, input longint d, input bit last);
      beat_t b;
      b.id1 = IW'(id1); b.id2 = IW'(id2); b.d = DW'(d); b.last = last;
      exp_q.push_back(b);
   endtask

   task automatic pushPairs();
      int n;
      longint dx, dy, dz;
      n = mdl_x.size();
      for (int i = 0; i < n - 1; i++)
         for (int j = i + 1; j < n; j++) begin
            dx = mdl_x[j] - mdl_x[i];
            dy = mdl_y[j] - mdl_y[i];
            dz = mdl_z[j] - mdl_z[i];
            pushBeat(i, j, dx*dx + dy*dy + dz*dz, (i == n - 2) && (j == n - 1));
         end
   endtask

   // Pops and compares one expected beat per observed out_valid. With
   // stop_beats>0 it returns right after that many beats; otherwise it runs
   // until done and then checks stream completeness and contiguity.
   task automatic checkOutput(input int budget, input int stop_beats,
                              output int first_cyc, output int nbeats);
      int    cyc;
      bit    ended, gap;
      beat_t obs, e;
      cyc = 0; ended = 0; gap = 0;
      first_cyc = -1; nbeats = 0;
      while (cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (o_valid) begin
            if (ended) gap = 1;
            if (first_cyc < 0) first_cyc = cyc;
            nbeats++;
            obs = {o_id1, o_id2, o_data, o_last};
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL beat_unexpected actual id1=%0d id2=%0d d=%0d last=%0b required none",
                        obs.id1, obs.id2, obs.d, obs.last);
            end else begin
               e = exp_q.pop_front();
               if (obs != e) begin
                  errors++;
                  $display("[TB] FAIL beat%0d actual id1=%0d id2=%0d d=%0d last=%0b required id1=%0d id2=%0d d=%0d last=%0b",
                           nbeats, obs.id1, obs.id2, obs.d, obs.last, e.id1, e.id2, e.d, e.last);
               end
            end
            if (stop_beats > 0 && nbeats == stop_beats) return;
         end else if (first_cyc >= 0) begin
            ended = 1;
         end
         if (o_done) break;
      end
      checkValue("beats_missing", exp_q.size(), 0);
      checkValue("done_reached", o_done, 1);
      checkValue("stream_gap", gap, 0);
   endtask

   vec_t vecs[7];
   int   first_cyc, nb;

   initial begin
      sel = 0;
      vecs[0] = '{ax:0, ay:0, az:0, bx:1, by:2, bz:2, d:9};
      vecs[1] = '{ax:0, ay:0, az:0, bx:20'hFFFFF, by:20'hFFFFF, bz:20'hFFFFF, d:64'd3298528591875};
      vecs[2] = '{ax:20'hFFFFF, ay:20'hFFFFF, az:20'hFFFFF, bx:0, by:0, bz:0, d:64'd3298528591875};
      vecs[3] = '{ax:5, ay:6, az:7, bx:5, by:6, bz:7, d:0};
      vecs[4] = '{ax:10, ay:0, az:0, bx:0, by:20, bz:0, d:500};
      vecs[5] = '{ax:20'hFFFFF, ay:0, az:0, bx:0, by:0, bz:0, d:64'd1099509530625};
      vecs[6] = '{ax:100, ay:200, az:300, bx:103, by:196, bz:312, d:169};

      // Reset state
      resetAll();
      @(negedge clk);
      checkValue("rst_out_valid", o_valid, 0);
      checkValue("rst_out_data", o_data, 0);
      checkValue("rst_out_ids", {o_id1, o_id2}, 0);
      checkValue("rst_out_last", o_last, 0);
      checkValue("rst_pt_ready", o_ready, 1);
      checkValue("rst_point_count", o_count, 0);
      checkValue("rst_overflow", o_ovf, 0);
      checkValue("rst_done", o_done, 0);

      // Three-point example with hand-derived distances
      resetAll();
      pushBeat(0, 1, 9, 0);
      pushBeat(0, 2, 25, 0);
      pushBeat(1, 2, 12, 1);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(1, 2, 2, 0);
      applyStimulus(3, 0, 4, 1);
      checkOutput(100, 0, first_cyc, nb);
      checkValue("three_first_beat_cycle", first_cyc, 4);
      checkValue("three_beats", nb, 3);
      checkValue("done_pt_ready", o_ready, 0);
      applyStimulus(7, 7, 7, 1);
      @(negedge clk);
      checkValue("done_ignores_count", o_count, 3);
      checkValue("done_ignores_ovf", o_ovf, 0);
      checkValue("done_held", o_done, 1);

      // Two-point arithmetic vectors
      for (int v = 0; v < 7; v++) begin
         resetAll();
         pushBeat(0, 1, vecs[v].d, 1);
         applyStimulus(vecs[v].ax, vecs[v].ay, vecs[v].az, 0);
         applyStimulus(vecs[v].bx, vecs[v].by, vecs[v].bz, 1);
         checkOutput(60, 0, first_cyc, nb);
         checkValue($sformatf("vec%0d_beats", v), nb, 1);
      end

      // Single point: straight to done
      resetAll();
      applyStimulus(5, 5, 5, 1);
      checkOutput(30, 0, first_cyc, nb);
      checkValue("single_beats", nb, 0);
      checkValue("single_count", o_count, 1);

      // MAX_POINTS=1 with two points: second is dropped
      sel = 1;
      resetAll();
      applyStimulus(1, 1, 1, 0);
      applyStimulus(2, 2, 2, 1);
      checkOutput(30, 0, first_cyc, nb);
      checkValue("max1_beats", nb, 0);
      checkValue("max1_overflow", o_ovf, 1);
      checkValue("max1_count", o_count, 1);

      // MAX_POINTS=4 with six points (k,0,0)
      sel = 2;
      resetAll();
      pushBeat(0, 1, 1, 0); pushBeat(0, 2, 4, 0); pushBeat(0, 3, 9, 0);
      pushBeat(1, 2, 1, 0); pushBeat(1, 3, 4, 0); pushBeat(2, 3, 1, 1);
      for (int k = 0; k < 6; k++) applyStimulus(k, 0, 0, k == 5);
      checkOutput(100, 0, first_cyc, nb);
      checkValue("max4_beats", nb, 6);
      checkValue("max4_overflow", o_ovf, 1);
      checkValue("max4_count", o_count, 4);

      // Reset during generation, then a fresh two-point load
      sel = 0;
      resetAll();
      for (int k = 0; k < 5; k++) applyStimulus(k * 3, k + 1, 50 - k, k == 4);
      pushPairs();
      checkOutput(100, 4, first_cyc, nb);
      checkValue("midrst_beats_before", nb, 4);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkValue("midrst_out_valid", o_valid, 0);
      checkValue("midrst_out_data", o_data, 0);
      checkValue("midrst_out_ids", {o_id1, o_id2}, 0);
      checkValue("midrst_out_last", o_last, 0);
      checkValue("midrst_pt_ready", o_ready, 1);
      checkValue("midrst_count", o_count, 0);
      checkValue("midrst_done", o_done, 0);
      resetAll();
      applyStimulus(1, 1, 1, 0);
      applyStimulus(4, 5, 1, 1);
      pushPairs();
      checkOutput(60, 0, first_cyc, nb);
      checkValue("midrst_fresh_beats", nb, 1);

      // Random 40-point load against the pair model
      resetAll();
      for (int k = 0; k < 40; k++)
         applyStimulus($urandom_range(0, 20'hFFFFF), $urandom_range(0, 20'hFFFFF),
                       $urandom_range(0, 20'hFFFFF), k == 39);
      pushPairs();
      checkOutput(3000, 0, first_cyc, nb);
      checkValue("rand40_beats", nb, 780);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pair_distance_generator.md
Name: pair_distance_generator

Overview:
- Upstream feeder for the systolic sorter.
- Loads a list of 3D points (junction-box coordinates), then enumerates every unordered pair (i<j).
- Computes each pair's squared Euclidean distance and streams it as in_valid/in_data/in_metadata/in_last beats, one per cycle with no backpressure.
- The sorter has no ready signal, so this block never stalls once generation starts.

Parameters:
- MAX_POINTS, 1024, point-memory depth; loads beyond this are dropped.
- COORD_WIDTH, 20, unsigned width of each coordinate.
- DIST_WIDTH, 64, output distance width; must be >= 2*COORD_WIDTH+4.
- INDEX_WIDTH, 32, width of each emitted point index.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- pt_valid  in  1  point beat valid
- pt_ready  out  1  high in LOAD state only
- pt_x, pt_y, pt_z  in  COORD_WIDTH each  unsigned coordinates
- pt_last  in  1  final point of the list
- out_valid  out  1  distance beat valid (drives sorter in_valid)
- out_data  out  DIST_WIDTH  squared distance
- out_id1  out  INDEX_WIDTH  lower point index i
- out_id2  out  INDEX_WIDTH  higher point index j
- out_last  out  1  marks final pair; qualified by out_valid
- point_count  out  INDEX_WIDTH  points stored
- overflow  out  1  sticky; a point was dropped
- done  out  1  generation complete; held until rst

Behaviour:
- Reset values:
  - state=LOAD, pt_ready=1.
  - out_valid=0, out_last=0, out_data=0, out_id1=0, out_id2=0.
  - point_count=0, overflow=0, done=0.
  - Pipeline valid bits cleared.
- Reset mid-operation aborts immediately; no further out_valid.
- LOAD:
  - A point is accepted when pt_valid && pt_ready.
  - If point_count<MAX_POINTS, it is written at address point_count and point_count increments.
  - Otherwise the point is discarded and overflow is set (sticky).
  - When an accepted beat carries pt_last: if point_count (after the write) >=2, go to GEN with i=0, j=1; else go to DONE.
- GEN:
  - Issues one pair address per cycle, ordered i=0..N-2, j=i+1..N-1.
  - When j==N-1, the next pair is i+1, i+2.
  - The issue carrying i=N-2, j=N-1 is tagged last, then the state moves to DRAIN.
  - Total beats = N(N-1)/2.
- DRAIN: waits until all pipeline valid bits clear, then moves to DONE.
- DONE: done=1, pt_ready=0, inputs ignored until rst.
- Pipeline: 3 stages, issue-to-output latency 3 cycles.
  - S1: synchronous read of both points from a dual-read memory.
  - S2: signed differences, each COORD_WIDTH+1 bits.
  - S3: squares summed, zero-extended to DIST_WIDTH, registered to outputs.
  - i, j and the last tag travel with the data.
- Output stream:
  - out_valid is high on contiguous cycles from the first to the last pair, with no bubbles.
  - out_last is high on exactly one beat.
  - out_id1 < out_id2 always.
  - Outputs hold their last values when out_valid=0; consumers ignore them.
- Arithmetic:
  - dx = x[j]-x[i], likewise dy, dz.
  - d = dx²+dy²+dz², exact, never truncated.
  - Equal points yield d=0.
- pt_valid while not in LOAD: ignored, not counted, no overflow.

Test Plan:
- Load (0,0,0), (1,2,2), (3,0,4) with pt_last on the third point.
  - Expect exactly 3 beats: (id1=0, id2=1, d=9), (0, 2, 25), (1, 2, 12).
  - out_last only on the third beat; valid contiguous; first beat 3 cycles after GEN entry; done high after drain.
- Single point with pt_last.
  - Expect zero out_valid beats, done=1, point_count=1.
  - Repeat with zero points: rst followed by pt_last on an overflowed-only stream (MAX_POINTS=0 is not legal, so use MAX_POINTS=1 with 2 points), giving overflow=1 and no beats.
- Extremes: (0,0,0) and (2^20-1, 2^20-1, 2^20-1).
  - Expect d = 3*(2^20-1)^2 = 3298528591875, no truncation.
  - Swapping load order gives the same d (negative diffs).
- MAX_POINTS=4, load 6 points (k,0,0) for k=0..5.
  - Expect overflow=1, point_count=4, and 6 beats in order (0,1,1), (0,2,4), (0,3,9), (1,2,1), (1,3,4), (2,3,1).
- Load 5 points, assert rst during the 4th GEN beat.
  - Expect out_valid=0 the next cycle, all outputs at reset values, pt_ready=1.
  - A fresh 2-point load then yields one beat with out_last=1.
- Random 40-point load checked against a software model.
  - Expect 780 beats, all pairs unique, correct d, and only the 780th beat carrying out_last.
